// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets NUM_REQ byte-stream requesters share one UART
// transmit buffer. A granted requester owns the transmit path for a whole
// message, ending at the byte flagged with req_last. Messages are optionally
// prefixed with a source-ID header byte (ID_BASE + requester index). A message
// whose owner stops supplying bytes for TIMEOUT cycles is aborted.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    [NUM_REQ]    per-requester byte valid
//   req_data     [8*NUM_REQ]  per-requester byte, requester i at [8i+7:8i]
//   req_last     [NUM_REQ]    final byte of a message
//   req_ready    [NUM_REQ]    per-requester byte accept (combinational)
//   tx_data      [8]          byte to the UART transmit buffer
//   tx_en        1            write strobe to the UART transmit buffer
//   tx_full      1            UART transmit buffer full, blocks writes
//   grant        [NUM_REQ]    one-hot registered owner, zero when idle
//   busy         1            arbiter is not idle
//   timeout_err  1            one-cycle pulse when a message is aborted
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int          NUM_REQ   = 4,
   parameter int          TIMEOUT   = 1024,
   parameter int          HEADER_EN = 1,
   parameter logic [7:0]  ID_BASE   = 8'h30
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_en,
   input  logic                 tx_full,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam state_t          GRANT_STATE = (HEADER_EN != 0) ? HEADER : STREAM;
   localparam logic [15:0]     CNT_LAST    = 16'(TIMEOUT - 1);
   // rr starts at the last index so that requester 0 is searched first.
   localparam logic [IW-1:0]   RR_RESET    = IW'(NUM_REQ - 1);

   state_t            state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]     gidx_q, gidx_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [15:0]       cnt_q, cnt_d;

   logic [7:0]        data_arr [NUM_REQ];
   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic              xfer;

   // Unpack the flat data bus so the granted byte is a simple array index.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         data_arr[i] = req_data[8*i +: 8];
      end
   end

   // Round-robin search starting one past the last owner.
   always_comb begin
      int            cand;
      logic [IW-1:0] cidx;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cidx      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cidx = IW'(cand);
         if (!win_found && req_valid[cidx]) begin
            win_found = 1'b1;
            win_idx   = cidx;
         end
      end
   end

   // Next-state and transmit-path logic. The data path outputs are
   // combinational so a tx_full or req_valid change acts in the same cycle.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      tx_en       = 1'b0;
      tx_data     = '0;
      req_ready   = '0;
      timeout_err = 1'b0;
      xfer        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d          = GRANT_STATE;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               gidx_d           = win_idx;
               cnt_d            = '0;
            end
         end

         HEADER: begin
            tx_data = ID_BASE + 8'(gidx_q);
            tx_en   = ~tx_full;
            if (!tx_full) begin
               state_d = STREAM;
               cnt_d   = '0;
            end
         end

         STREAM: begin
            tx_data           = data_arr[gidx_q];
            req_ready[gidx_q] = ~tx_full;
            xfer              = req_valid[gidx_q] & ~tx_full;
            tx_en             = xfer;
            if (xfer) begin
               cnt_d = '0;
               if (req_last[gidx_q]) begin
                  state_d = IDLE;
                  grant_d = '0;
                  rr_d    = gidx_q;
               end
            end else if (!req_valid[gidx_q] && !tx_full) begin
               // Only cycles where the owner itself is silent count toward
               // the timeout; back-pressure from the UART never does.
               if (cnt_q == CNT_LAST) begin
                  timeout_err = 1'b1;
                  state_d     = IDLE;
                  grant_d     = '0;
                  rr_d        = gidx_q;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= RR_RESET;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=8, HEADER_EN=1,
// ID_BASE=8'h30). Requesters are driven from small per-requester byte tables;
// every transmit write and every new grant is logged and compared against
// hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_en;
   logic           tx_full;
   logic [N-1:0]   grant;
   logic           busy;
   logic           timeout_err;

   // Source tables: bit 8 is the last flag, bits 7:0 the byte.
   logic [8:0]     src_mem [N][16];
   int             src_rd  [N];
   int             src_wr  [N];

   logic [7:0]     txlog[$];
   int             glog[$];
   logic [N-1:0]   prev_grant;
   int             cyc;
   int             last_xfer_cyc;
   int             to_cnt;
   int             to_gap;

   int             vectors     = 0;
   int             miscompares = 0;

   uart_tx_arbiter #(
      .NUM_REQ   (N),
      .TIMEOUT   (8),
      .HEADER_EN (1),
      .ID_BASE   (8'h30)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_en       (tx_en),
      .tx_full     (tx_full),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push_byte(input int r, input logic [7:0] d, input logic l);
      src_mem[r][src_wr[r]] = {l, d};
      src_wr[r]++;
   endtask

   task automatic drive_inputs();
      for (int r = 0; r < N; r++) begin
         if (src_rd[r] < src_wr[r]) begin
            req_valid[r]       = 1'b1;
            req_data[8*r +: 8] = src_mem[r][src_rd[r]][7:0];
            req_last[r]        = src_mem[r][src_rd[r]][8];
         end else begin
            req_valid[r]       = 1'b0;
            req_data[8*r +: 8] = 8'h00;
            req_last[r]        = 1'b0;
         end
      end
   endtask

   function automatic bit sources_empty();
      for (int r = 0; r < N; r++) if (src_rd[r] < src_wr[r]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock cycle: sample outputs mid-cycle, log, advance, refresh inputs.
   task automatic cycle();
      logic [N-1:0] acc;
      acc = req_valid & req_ready;
      vectors++;
      if (tx_en && tx_full) begin
         miscompares++;
         $display("FAIL no_write_when_full: tx_en=%0b tx_full=%0b required tx_en=0", tx_en, tx_full);
      end
      vectors++;
      if ($countones(grant) > 1) begin
         miscompares++;
         $display("FAIL grant_onehot: grant=%b required at most one bit", grant);
      end
      vectors++;
      if ((req_ready & ~grant) !== '0) begin
         miscompares++;
         $display("FAIL ready_only_owner: req_ready=%b grant=%b", req_ready, grant);
      end
      if (prev_grant != '0 && grant != '0 && grant != prev_grant) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_gap: grant %b -> %b with no idle cycle", prev_grant, grant);
      end
      if (tx_en) txlog.push_back(tx_data);
      if (acc != '0) last_xfer_cyc = cyc;
      if (timeout_err) begin
         to_cnt++;
         to_gap = cyc - last_xfer_cyc;
      end
      if (grant != '0 && grant != prev_grant) begin
         for (int r = 0; r < N; r++) if (grant[r]) glog.push_back(r);
      end
      prev_grant = grant;
      @(posedge clk);
      #1;
      cyc++;
      for (int r = 0; r < N; r++) if (acc[r]) src_rd[r]++;
      drive_inputs();
      #1;
   endtask

   task automatic run_until_idle(input string name);
      int budget;
      budget = 400;
      while (!(busy === 1'b0 && sources_empty()) && budget > 0) begin
         cycle();
         budget--;
      end
      if (budget == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_idle_timeout: busy=%0b still set, required idle", name, busy);
      end
   endtask

   task automatic run_until_tx(input int n, input string name);
      int budget;
      budget = 200;
      while (txlog.size() < n && budget > 0) begin
         cycle();
         budget--;
      end
      if (budget == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_tx_timeout: %0d writes seen, required %0d", name, txlog.size(), n);
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      tx_full  = 1'b0;
      for (int r = 0; r < N; r++) begin
         src_rd[r] = 0;
         src_wr[r] = 0;
      end
      drive_inputs();
      txlog.delete();
      glog.delete();
      prev_grant    = '0;
      to_cnt        = 0;
      to_gap        = -1;
      last_xfer_cyc = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = 32'hA5A5_A5A5;
      #1;
      vectors++;
      if ({grant, busy, tx_en, req_ready, timeout_err, tx_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: grant=%b busy=%0b tx_en=%0b ready=%b to=%0b tx_data=%h required all 0",
                  grant, busy, tx_en, req_ready, timeout_err, tx_data);
      end
      do_reset();
      cycle();
      vectors++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_no_req: grant=%b busy=%0b required 0000/0", grant, busy);
      end
      // Grant appears exactly one cycle after valid is first seen in IDLE.
      push_byte(2, 8'h77, 1'b1);
      drive_inputs();
      #1;
      vectors++;
      if (grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL grant_latency_early: grant=%b required 0000", grant);
      end
      cycle();
      vectors++;
      if (grant !== 4'b0100 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL grant_latency: grant=%b busy=%0b required 0100/1", grant, busy);
      end
      run_until_idle("latency");
   endtask

   task automatic test_alternate();
      logic [7:0] exp_tx [12];
      int         exp_g  [4];
      exp_tx = '{8'h31, 8'hA1, 8'hA2, 8'h33, 8'hC1, 8'hC2,
                 8'h31, 8'hA3, 8'hA4, 8'h33, 8'hC3, 8'hC4};
      exp_g  = '{1, 3, 1, 3};
      do_reset();
      push_byte(1, 8'hA1, 1'b0); push_byte(1, 8'hA2, 1'b1);
      push_byte(1, 8'hA3, 1'b0); push_byte(1, 8'hA4, 1'b1);
      push_byte(3, 8'hC1, 1'b0); push_byte(3, 8'hC2, 1'b1);
      push_byte(3, 8'hC3, 1'b0); push_byte(3, 8'hC4, 1'b1);
      drive_inputs();
      #1;
      run_until_idle("alternate");
      vectors++;
      if (glog.size() != 4) begin
         miscompares++;
         $display("FAIL alt_grant_count: got %0d required 4", glog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (glog[i] != exp_g[i]) begin
               miscompares++;
               $display("FAIL alt_grant[%0d]: got %0d required %0d", i, glog[i], exp_g[i]);
            end
         end
      end
      vectors++;
      if (txlog.size() != 12) begin
         miscompares++;
         $display("FAIL alt_tx_count: got %0d required 12", txlog.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            vectors++;
            if (txlog[i] !== exp_tx[i]) begin
               miscompares++;
               $display("FAIL alt_tx[%0d]: got %h required %h", i, txlog[i], exp_tx[i]);
            end
         end
      end
   endtask

   task automatic test_three_byte();
      logic [7:0] exp_tx [4];
      exp_tx = '{8'h30, 8'hAA, 8'hBB, 8'hCC};
      do_reset();
      push_byte(0, 8'hAA, 1'b0);
      push_byte(0, 8'hBB, 1'b0);
      push_byte(0, 8'hCC, 1'b1);
      drive_inputs();
      #1;
      run_until_tx(4, "three");
      vectors++;
      if (grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL three_grant_clear: grant=%b required 0000 after last byte", grant);
      end
      repeat (3) cycle();
      vectors++;
      if (txlog.size() != 4) begin
         miscompares++;
         $display("FAIL three_tx_count: got %0d required 4", txlog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (txlog[i] !== exp_tx[i]) begin
               miscompares++;
               $display("FAIL three_tx[%0d]: got %h required %h", i, txlog[i], exp_tx[i]);
            end
         end
      end
   endtask

   task automatic test_tx_full_stall();
      logic [7:0] exp_tx [5];
      exp_tx = '{8'h32, 8'h21, 8'h22, 8'h23, 8'h24};
      do_reset();
      push_byte(2, 8'h21, 1'b0); push_byte(2, 8'h22, 1'b0);
      push_byte(2, 8'h23, 1'b0); push_byte(2, 8'h24, 1'b1);
      drive_inputs();
      #1;
      run_until_tx(2, "stall");
      for (int i = 0; i < 5; i++) begin
         tx_full = 1'b1;
         #1;
         vectors++;
         if (tx_en !== 1'b0 || req_ready !== 4'b0000 || timeout_err !== 1'b0 || grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL stall_cycle%0d: tx_en=%0b ready=%b to=%0b grant=%b required 0/0000/0/0100",
                     i, tx_en, req_ready, timeout_err, grant);
         end
         cycle();
      end
      tx_full = 1'b0;
      #1;
      run_until_idle("stall");
      vectors++;
      if (to_cnt != 0) begin
         miscompares++;
         $display("FAIL stall_no_timeout: got %0d pulses required 0", to_cnt);
      end
      vectors++;
      if (txlog.size() != 5) begin
         miscompares++;
         $display("FAIL stall_tx_count: got %0d required 5", txlog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (txlog[i] !== exp_tx[i]) begin
               miscompares++;
               $display("FAIL stall_tx[%0d]: got %h required %h", i, txlog[i], exp_tx[i]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] exp_tx [5];
      exp_tx = '{8'h30, 8'h5A, 8'h31, 8'h61, 8'h62};
      do_reset();
      push_byte(0, 8'h5A, 1'b0);
      push_byte(1, 8'h61, 1'b0);
      push_byte(1, 8'h62, 1'b1);
      drive_inputs();
      #1;
      run_until_idle("timeout");
      vectors++;
      if (to_cnt != 1) begin
         miscompares++;
         $display("FAIL to_pulse_count: got %0d required 1", to_cnt);
      end
      vectors++;
      if (to_gap != 8) begin
         miscompares++;
         $display("FAIL to_gap: got %0d cycles required 8", to_gap);
      end
      vectors++;
      if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1) begin
         miscompares++;
         $display("FAIL to_grants: got %0d grants (first %0d) required 0,1",
                  glog.size(), (glog.size() > 0) ? glog[0] : -1);
      end
      vectors++;
      if (txlog.size() != 5) begin
         miscompares++;
         $display("FAIL to_tx_count: got %0d required 5", txlog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (txlog[i] !== exp_tx[i]) begin
               miscompares++;
               $display("FAIL to_tx[%0d]: got %h required %h", i, txlog[i], exp_tx[i]);
            end
         end
      end
   endtask

   task automatic test_all_valid();
      int exp_g [5];
      exp_g = '{0, 1, 2, 3, 0};
      do_reset();
      push_byte(0, 8'h00, 1'b0); push_byte(0, 8'h01, 1'b1);
      push_byte(0, 8'h02, 1'b0); push_byte(0, 8'h03, 1'b1);
      push_byte(1, 8'h10, 1'b0); push_byte(1, 8'h11, 1'b1);
      push_byte(2, 8'h20, 1'b0); push_byte(2, 8'h21, 1'b1);
      push_byte(3, 8'h40, 1'b0); push_byte(3, 8'h41, 1'b1);
      drive_inputs();
      #1;
      run_until_idle("allvalid");
      vectors++;
      if (glog.size() != 5) begin
         miscompares++;
         $display("FAIL all_grant_count: got %0d required 5", glog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (glog[i] != exp_g[i]) begin
               miscompares++;
               $display("FAIL all_grant[%0d]: got %0d required %0d", i, glog[i], exp_g[i]);
            end
         end
      end
      vectors++;
      if (txlog.size() != 15) begin
         miscompares++;
         $display("FAIL all_tx_count: got %0d required 15", txlog.size());
      end
   endtask

   task automatic test_reset_mid_stream();
      logic [7:0] exp_tx [8];
      exp_tx = '{8'h30, 8'hB0, 8'h31, 8'hB1, 8'h32, 8'hB2, 8'h33, 8'hB3};
      do_reset();
      push_byte(0, 8'h91, 1'b0); push_byte(0, 8'h92, 1'b0);
      push_byte(0, 8'h93, 1'b0); push_byte(0, 8'h94, 1'b1);
      drive_inputs();
      #1;
      run_until_tx(3, "midreset");
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({grant, busy, tx_en, req_ready, timeout_err, tx_data} !== '0) begin
         miscompares++;
         $display("FAIL midreset_outputs: grant=%b busy=%0b tx_en=%0b ready=%b to=%0b tx_data=%h required all 0",
                  grant, busy, tx_en, req_ready, timeout_err, tx_data);
      end
      // Fresh single-byte messages from every requester after release.
      do_reset();
      for (int r = 0; r < N; r++) push_byte(r, 8'hB0 + 8'(r), 1'b1);
      drive_inputs();
      #1;
      run_until_idle("midreset");
      vectors++;
      if (to_cnt != 0) begin
         miscompares++;
         $display("FAIL midreset_no_timeout: got %0d pulses required 0", to_cnt);
      end
      vectors++;
      if (glog.size() < 1 || glog[0] != 0) begin
         miscompares++;
         $display("FAIL midreset_first_grant: got %0d required 0", (glog.size() > 0) ? glog[0] : -1);
      end
      vectors++;
      if (txlog.size() != 8) begin
         miscompares++;
         $display("FAIL midreset_tx_count: got %0d required 8", txlog.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (txlog[i] !== exp_tx[i]) begin
               miscompares++;
               $display("FAIL midreset_tx[%0d]: got %h required %h", i, txlog[i], exp_tx[i]);
            end
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      tx_full   = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      cyc       = 0;
      test_reset();
      test_alternate();
      test_three_byte();
      test_tx_full_stall();
      test_timeout();
      test_all_valid();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 1024: stall cycles before a granted message is aborted, range 2..65535.
REQ-003 Parameter HEADER_EN, default 1: 1 = prefix each message with a source-ID byte.
REQ-004 Parameter ID_BASE, default 8'h30: header byte = ID_BASE + granted index, modulo 256.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-008 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-009 req_last  input  NUM_REQ  marks the final byte of a message.
REQ-010 req_ready  output  NUM_REQ  per-requester byte accept.
REQ-011 tx_data  output  8  byte to the UART transmit buffer (tx_data of uart_with_buffer).
REQ-012 tx_en  output  1  one-cycle write strobe to the UART transmit buffer.
REQ-013 tx_full  input  1  UART transmit buffer full; no write is issued while high.
REQ-014 grant  output  NUM_REQ  one-hot registered owner of the transmit path; all-zero when idle.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 timeout_err  output  1  one-cycle pulse when a message is aborted by timeout.

Function
REQ-017 FSM states: IDLE, HEADER, STREAM; state, grant, rr pointer and timeout counter are registered.
REQ-018 IDLE: if any req_valid is high, the next cycle enters HEADER (HEADER_EN=1) or STREAM (HEADER_EN=0) with grant set to the winner; otherwise stay in IDLE.
REQ-019 Arbitration: round-robin, searching from index (rr+1) mod NUM_REQ upward; only req_valid is considered, not req_last.
REQ-020 Arbitration latency: grant is asserted exactly one cycle after req_valid is first sampled high in IDLE.
REQ-021 HEADER: tx_en = ~tx_full, tx_data = ID_BASE + index; on that write, go to STREAM; while tx_full is high, hold in HEADER.
REQ-022 STREAM transfer condition: req_valid[g] & ~tx_full, where g is the granted index.
REQ-023 STREAM outputs: req_ready[g] = ~tx_full; tx_en = transfer; tx_data = req_data[g]; all are combinational, with zero-cycle latency from tx_full and req_valid.
REQ-024 Non-granted requesters always see req_ready = 0; req_ready is 0 in IDLE and HEADER.
REQ-025 Transfer with req_last[g] = 1: next state IDLE, grant cleared, rr <= g; the message is never interleaved with another requester.
REQ-026 Timeout counter: cleared on entry to STREAM and on every transfer; increments each STREAM cycle with req_valid[g] = 0; cycles stalled by tx_full do not count.
REQ-027 When the counter reaches TIMEOUT-1 with req_valid[g] still low: timeout_err pulses for one cycle, next state IDLE, grant cleared, rr <= g, and no byte is written.
REQ-028 A message may be a single byte (req_last on the first byte); in that case 2 bytes are written with HEADER_EN=1 and 1 byte with HEADER_EN=0.
REQ-029 tx_en is never asserted while tx_full is high, and is never asserted in IDLE.
REQ-030 Back-to-back messages: at least one IDLE cycle separates consecutive grants.

Reset
REQ-031 While rst_n is low: state = IDLE, grant = 0, busy = 0, tx_en = 0, req_ready = 0, timeout_err = 0, counter = 0, tx_data = 0, rr = NUM_REQ-1 (requester 0 has first priority).
REQ-032 Reset asserted mid-message aborts the message immediately; no timeout_err pulse is produced, and the partial message is not resumed after reset release.

Verification
REQ-033 After reset, req_valid=4'b1010 held, each message 2 bytes -> grants in order 1, 3, 1, 3; header bytes 8'h31 and 8'h33 precede the data.
REQ-034 Requester 0 sends 3 bytes AA, BB, CC (last on CC), HEADER_EN=1 -> tx_en writes 30, AA, BB, CC in exactly 4 write cycles; grant[0] clears the cycle after CC.
REQ-035 tx_full held high for 5 cycles in the middle of a message -> no tx_en and req_ready[g]=0 for those 5 cycles, no timeout, stream resumes with the next byte.
REQ-036 TIMEOUT=8, granted requester drops req_valid after its first byte -> timeout_err pulses once, 8 cycles after the last transfer; the FSM returns to IDLE and the next requester is granted.
REQ-037 All 4 requesters valid simultaneously -> grant sequence 0, 1, 2, 3, 0; no two grant bits are ever high together.
REQ-038 rst_n pulsed low during STREAM -> all outputs are 0 within the same cycle; after release, requester 0 wins when all requesters are valid.
